// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the instruction/data memory arbiter and the load decoder.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        LP_IDLE = 2'd0,
        LP_REQ  = 2'd1,
        LP_RSP  = 2'd2,
        LP_DONE = 2'd3
    } mem_state_e;

    typedef enum logic {
        LP_OWN_IF = 1'b0,
        LP_OWN_DM = 1'b1
    } mem_owner_e;

    localparam logic [1:0] LP_SIZE_B = 2'b00;
    localparam logic [1:0] LP_SIZE_H = 2'b01;
    localparam logic [1:0] LP_SIZE_W = 2'b10;

endpackage

// File: rtl/riscv_mem_lane.sv
// Byte-lane steering for load/store accesses: byte enables, lane-replicated
// store data and the misalignment flag, all derived from size and addr[1:0].
module riscv_mem_lane
    import riscv_mem_pkg::*;
#(
    parameter int MP_DATA_WIDTH = 32
)(
    input  logic [1:0]               size,
    input  logic [1:0]               addr_lo,
    input  logic [MP_DATA_WIDTH-1:0] wdata,
    output logic [3:0]               be,
    output logic [MP_DATA_WIDTH-1:0] wdata_rep,
    output logic                     misalign
);

    // Lane selection and replication for the requested access size
    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        misalign  = 1'b0;
        case (size)
            LP_SIZE_B: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {(MP_DATA_WIDTH/8){wdata[7:0]}};
            end
            LP_SIZE_H: begin
                be        = 4'b0011 << addr_lo;
                wdata_rep = {(MP_DATA_WIDTH/16){wdata[15:0]}};
                misalign  = addr_lo[0];
            end
            LP_SIZE_W: begin
                be       = 4'b1111;
                misalign = (addr_lo != 2'b00);
            end
            // Unused size code behaves like a word access
            default: begin
                be       = 4'b1111;
                misalign = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store. Commands,
// read data and completion pulses are registered; stall requests are combinational.
module riscv_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int MP_DATA_WIDTH   = 32,
    parameter int MP_ADDR_WIDTH   = 32,
    parameter int MP_STARVE_LIMIT = 4,
    parameter int MP_CNT_WIDTH    = 3
)(
    input  logic                     iclk,
    input  logic                     irst,
    input  logic                     iif_req,
    input  logic [MP_ADDR_WIDTH-1:0] iif_addr,
    output logic [MP_DATA_WIDTH-1:0] oif_rdata,
    output logic                     oif_valid,
    input  logic                     idm_req,
    input  logic                     idm_we,
    input  logic [1:0]               idm_size,
    input  logic [MP_ADDR_WIDTH-1:0] idm_addr,
    input  logic [MP_DATA_WIDTH-1:0] idm_wdata,
    output logic [MP_DATA_WIDTH-1:0] odm_rdata,
    output logic                     odm_valid,
    output logic                     odm_err,
    output logic                     omem_req,
    output logic                     omem_we,
    output logic [3:0]               omem_be,
    output logic [MP_ADDR_WIDTH-1:0] omem_addr,
    output logic [MP_DATA_WIDTH-1:0] omem_wdata,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [MP_DATA_WIDTH-1:0] imem_rdata,
    output logic                     ostall_if,
    output logic                     ostall_dm
);

    localparam logic [MP_ADDR_WIDTH-1:0] LP_WORD_MASK = {{(MP_ADDR_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [MP_CNT_WIDTH-1:0]  LP_CNT_SAT   = MP_CNT_WIDTH'(MP_STARVE_LIMIT);
    localparam logic [MP_CNT_WIDTH-1:0]  LP_CNT_ONE   = {{(MP_CNT_WIDTH-1){1'b0}}, 1'b1};

    mem_state_e                 state_r,     state_s;
    mem_owner_e                 owner_r,     owner_s;
    logic [MP_CNT_WIDTH-1:0]    cnt_r,       cnt_s;
    logic                       mem_req_r,   mem_req_s;
    logic                       mem_we_r,    mem_we_s;
    logic [3:0]                 mem_be_r,    mem_be_s;
    logic [MP_ADDR_WIDTH-1:0]   mem_addr_r,  mem_addr_s;
    logic [MP_DATA_WIDTH-1:0]   mem_wdata_r, mem_wdata_s;
    logic [MP_DATA_WIDTH-1:0]   if_rdata_r,  if_rdata_s;
    logic                       if_valid_r,  if_valid_s;
    logic [MP_DATA_WIDTH-1:0]   dm_rdata_r,  dm_rdata_s;
    logic                       dm_valid_r,  dm_valid_s;
    logic                       dm_err_r,    dm_err_s;

    logic [3:0]                 lane_be_s;
    logic [MP_DATA_WIDTH-1:0]   lane_wdata_s;
    logic                       lane_misalign_s;
    logic                       if_win_s;

    riscv_mem_lane #(
        .MP_DATA_WIDTH (MP_DATA_WIDTH)
    ) u_lane (
        .size      (idm_size),
        .addr_lo   (idm_addr[1:0]),
        .wdata     (idm_wdata),
        .be        (lane_be_s),
        .wdata_rep (lane_wdata_s),
        .misalign  (lane_misalign_s)
    );

    // Fetch wins when data is idle or data has used up its starvation allowance
    assign if_win_s = iif_req & (~idm_req | (cnt_r == LP_CNT_SAT));

    // Next-state, arbitration and registered-output update
    always_comb begin
        state_s     = state_r;
        owner_s     = owner_r;
        cnt_s       = cnt_r;
        mem_req_s   = mem_req_r;
        mem_we_s    = mem_we_r;
        mem_be_s    = mem_be_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        if_rdata_s  = if_rdata_r;
        if_valid_s  = 1'b0;
        dm_rdata_s  = dm_rdata_r;
        dm_valid_s  = 1'b0;
        dm_err_s    = 1'b0;

        if (!iif_req) begin
            cnt_s = {MP_CNT_WIDTH{1'b0}};
        end else begin
            cnt_s = cnt_r;
        end

        case (state_r)
            LP_IDLE: begin
                if (if_win_s) begin
                    owner_s     = LP_OWN_IF;
                    cnt_s       = {MP_CNT_WIDTH{1'b0}};
                    mem_req_s   = 1'b1;
                    mem_we_s    = 1'b0;
                    mem_be_s    = 4'b1111;
                    mem_addr_s  = iif_addr & LP_WORD_MASK;
                    mem_wdata_s = {MP_DATA_WIDTH{1'b0}};
                    state_s     = LP_REQ;
                end else if (idm_req && lane_misalign_s) begin
                    // Rejected without touching memory; counter untouched
                    dm_valid_s = 1'b1;
                    dm_err_s   = 1'b1;
                end else if (idm_req) begin
                    owner_s     = LP_OWN_DM;
                    mem_req_s   = 1'b1;
                    mem_we_s    = idm_we;
                    mem_be_s    = lane_be_s;
                    mem_addr_s  = idm_addr & LP_WORD_MASK;
                    mem_wdata_s = lane_wdata_s;
                    state_s     = LP_REQ;
                    if (iif_req && (cnt_r != LP_CNT_SAT)) begin
                        cnt_s = cnt_r + LP_CNT_ONE;
                    end else begin
                        cnt_s = cnt_s;
                    end
                end else begin
                    state_s = LP_IDLE;
                end
            end
            LP_REQ: begin
                if (imem_gnt) begin
                    mem_req_s = 1'b0;
                    state_s   = LP_RSP;
                end else begin
                    state_s = LP_REQ;
                end
            end
            LP_RSP: begin
                if (imem_rvalid) begin
                    if (owner_r == LP_OWN_IF) begin
                        if_rdata_s = imem_rdata;
                    end else begin
                        dm_rdata_s = imem_rdata;
                    end
                    state_s = LP_DONE;
                end else begin
                    state_s = LP_RSP;
                end
            end
            LP_DONE: begin
                if (owner_r == LP_OWN_IF) begin
                    if_valid_s = 1'b1;
                end else begin
                    dm_valid_s = 1'b1;
                end
                state_s = LP_IDLE;
            end
            default: begin
                state_s   = LP_IDLE;
                mem_req_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any outstanding transaction
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_r     <= LP_IDLE;
            owner_r     <= LP_OWN_IF;
            cnt_r       <= {MP_CNT_WIDTH{1'b0}};
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_be_r    <= 4'b0000;
            mem_addr_r  <= {MP_ADDR_WIDTH{1'b0}};
            mem_wdata_r <= {MP_DATA_WIDTH{1'b0}};
            if_rdata_r  <= {MP_DATA_WIDTH{1'b0}};
            if_valid_r  <= 1'b0;
            dm_rdata_r  <= {MP_DATA_WIDTH{1'b0}};
            dm_valid_r  <= 1'b0;
            dm_err_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            owner_r     <= owner_s;
            cnt_r       <= cnt_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_be_r    <= mem_be_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            if_rdata_r  <= if_rdata_s;
            if_valid_r  <= if_valid_s;
            dm_rdata_r  <= dm_rdata_s;
            dm_valid_r  <= dm_valid_s;
            dm_err_r    <= dm_err_s;
        end
    end

    assign omem_req   = mem_req_r;
    assign omem_we    = mem_we_r;
    assign omem_be    = mem_be_r;
    assign omem_addr  = mem_addr_r;
    assign omem_wdata = mem_wdata_r;
    assign oif_rdata  = if_rdata_r;
    assign oif_valid  = if_valid_r;
    assign odm_rdata  = dm_rdata_r;
    assign odm_valid  = dm_valid_r;
    assign odm_err    = dm_err_r;
    assign ostall_if  = iif_req & ~if_valid_r;
    assign ostall_dm  = idm_req & ~dm_valid_r;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter with a simple memory responder
// whose grant and response delays are set per test.
module tb_riscv_mem_arbiter;
    import riscv_mem_pkg::*;

    logic        iclk, irst;
    logic        iif_req;
    logic [31:0] iif_addr, oif_rdata;
    logic        oif_valid;
    logic        idm_req, idm_we;
    logic [1:0]  idm_size;
    logic [31:0] idm_addr, idm_wdata, odm_rdata;
    logic        odm_valid, odm_err;
    logic        omem_req, omem_we;
    logic [3:0]  omem_be;
    logic [31:0] omem_addr, omem_wdata;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ostall_if, ostall_dm;

    int n_checks = 0;
    int n_fail   = 0;
    int gnt_delay = 0;
    int rsp_delay = 0;
    bit spur = 1'b0;

    logic [31:0] g_addr[$];
    logic [3:0]  g_be[$];
    logic        g_we[$];
    logic [31:0] g_wdata[$];

    bit          rsp_due = 1'b0;
    int          rsp_cnt = 0;
    int          wait_n  = 0;
    logic [31:0] rsp_data  = 32'h0;
    logic [31:0] hold_addr = 32'h0;
    logic [3:0]  hold_be   = 4'h0;

    riscv_mem_arbiter #(
        .MP_DATA_WIDTH   (32),
        .MP_ADDR_WIDTH   (32),
        .MP_STARVE_LIMIT (4),
        .MP_CNT_WIDTH    (3)
    ) dut (
        .iclk        (iclk),
        .irst        (irst),
        .iif_req     (iif_req),
        .iif_addr    (iif_addr),
        .oif_rdata   (oif_rdata),
        .oif_valid   (oif_valid),
        .idm_req     (idm_req),
        .idm_we      (idm_we),
        .idm_size    (idm_size),
        .idm_addr    (idm_addr),
        .idm_wdata   (idm_wdata),
        .odm_rdata   (odm_rdata),
        .odm_valid   (odm_valid),
        .odm_err     (odm_err),
        .omem_req    (omem_req),
        .omem_we     (omem_we),
        .omem_be     (omem_be),
        .omem_addr   (omem_addr),
        .omem_wdata  (omem_wdata),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .ostall_if   (ostall_if),
        .ostall_dm   (ostall_dm)
    );

    initial begin
        iclk = 1'b0;
        forever #5 iclk = ~iclk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0050_0093;
        else return 32'hC0DE_0000 | a;
    endfunction

    // Memory responder: grants after gnt_delay waiting cycles, answers rsp_delay cycles later
    initial begin
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        forever begin
            @(negedge iclk);
            imem_gnt = 1'b0;
            imem_rvalid = 1'b0;
            if (spur) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hDEAD_BEEF;
            end else if (rsp_due) begin
                if (rsp_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = rsp_data;
                    rsp_due     = 1'b0;
                end else begin
                    rsp_cnt--;
                end
            end else if (omem_req === 1'b1) begin
                if (wait_n == 0) begin
                    hold_addr = omem_addr;
                    hold_be   = omem_be;
                end else begin
                    check_eq("cmd_stable_addr", omem_addr, hold_addr);
                    check_eq("cmd_stable_be", {28'd0, omem_be}, {28'd0, hold_be});
                end
                if (wait_n >= gnt_delay) begin
                    imem_gnt = 1'b1;
                    rsp_due  = 1'b1;
                    rsp_cnt  = rsp_delay;
                    rsp_data = omem_we ? 32'h0 : mem_word(omem_addr);
                    g_addr.push_back(omem_addr);
                    g_be.push_back(omem_be);
                    g_we.push_back(omem_we);
                    g_wdata.push_back(omem_wdata);
                    wait_n = 0;
                end else begin
                    wait_n++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_until_if(input bit hold_dm, output int t_dm, output int t_if);
        int cyc = 0;
        bit stall_ok = 1'b1;
        t_dm = -1;
        t_if = -1;
        while (t_if < 0 && cyc < 120) begin
            @(posedge iclk); #1;
            cyc++;
            if (odm_valid && t_dm < 0) t_dm = cyc;
            if (odm_valid && !hold_dm) idm_req = 1'b0;
            if (oif_valid) begin
                t_if = cyc;
                check_eq("stall_if_release", ostall_if, 1'b0);
                iif_req = 1'b0;
                idm_req = 1'b0;
            end else if (ostall_if !== 1'b1) begin
                stall_ok = 1'b0;
            end
        end
        check_eq("stall_if_held", stall_ok, 1'b1);
        check_eq("if_done", t_if >= 0, 1'b1);
    endtask

    task automatic run_dm(input bit exp_stall1, output int t, output logic err);
        int cyc = 0;
        t = -1;
        err = 1'b0;
        while (t < 0 && cyc < 40) begin
            @(posedge iclk); #1;
            cyc++;
            if (cyc == 1) check_eq("stall_dm_c1", ostall_dm, exp_stall1);
            if (odm_valid) begin
                t = cyc;
                err = odm_err;
                idm_req = 1'b0;
            end
        end
        check_eq("dm_done", t >= 0, 1'b1);
    endtask

    task automatic set_dm(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        idm_req = 1'b1; idm_we = we; idm_size = sz; idm_addr = a; idm_wdata = wd;
    endtask

    initial begin
        int t_dm, t_if, t, base, seen;
        logic err;
        irst = 1'b1; iif_req = 1'b0; iif_addr = 32'h0;
        idm_req = 1'b0; idm_we = 1'b0; idm_size = LP_SIZE_W; idm_addr = 32'h0; idm_wdata = 32'h0;
        repeat (3) @(posedge iclk);
        #1;
        check_eq("rst_omem_req", omem_req, 1'b0);
        check_eq("rst_omem_be", {28'd0, omem_be}, 32'h0);
        check_eq("rst_if_valid", oif_valid, 1'b0);
        check_eq("rst_dm_valid", odm_valid, 1'b0);
        check_eq("rst_dm_err", odm_err, 1'b0);
        check_eq("rst_if_rdata", oif_rdata, 32'h0);
        @(negedge iclk); irst = 1'b0;

        // Fetch only
        base = g_addr.size();
        @(negedge iclk); iif_req = 1'b1; iif_addr = 32'h0000_0100;
        run_until_if(1'b0, t_dm, t_if);
        check_eq("fetch_latency", t_if, 4);
        check_eq("fetch_rdata", oif_rdata, 32'h0050_0093);
        check_eq("fetch_grants", g_addr.size() - base, 1);
        check_eq("fetch_addr", g_addr[base], 32'h0000_0100);
        check_eq("fetch_be", {28'd0, g_be[base]}, 32'hF);
        check_eq("fetch_we", g_we[base], 1'b0);
        @(posedge iclk); #1;
        check_eq("fetch_pulse_1cyc", oif_valid, 1'b0);

        // Simultaneous requests: data first, fetch back-to-back after
        base = g_addr.size();
        @(negedge iclk);
        iif_req = 1'b1; iif_addr = 32'h0000_0104;
        set_dm(1'b0, LP_SIZE_W, 32'h0000_0204, 32'h0);
        run_until_if(1'b0, t_dm, t_if);
        check_eq("simul_t_dm", t_dm, 4);
        check_eq("simul_t_if", t_if, 8);
        check_eq("simul_dm_rdata", odm_rdata, 32'hC0DE_0204);
        check_eq("simul_if_rdata", oif_rdata, 32'hC0DE_0104);
        check_eq("simul_first", g_addr[base], 32'h0000_0204);
        check_eq("simul_second", g_addr[base+1], 32'h0000_0104);

        // Starvation: data held high, fetch wins on the fifth grant
        base = g_addr.size();
        @(negedge iclk);
        iif_req = 1'b1; iif_addr = 32'h0000_0108;
        set_dm(1'b0, LP_SIZE_W, 32'h0000_0300, 32'h0);
        run_until_if(1'b1, t_dm, t_if);
        check_eq("starve_grants", g_addr.size() - base, 5);
        check_eq("starve_dm4", g_addr[base+3], 32'h0000_0300);
        check_eq("starve_if", g_addr[base+4], 32'h0000_0108);
        base = g_addr.size();
        @(negedge iclk);
        iif_req = 1'b1; iif_addr = 32'h0000_010C;
        set_dm(1'b0, LP_SIZE_W, 32'h0000_0304, 32'h0);
        run_until_if(1'b0, t_dm, t_if);
        check_eq("starve_cleared_dm_first", g_addr[base], 32'h0000_0304);

        // Stores and misalignment
        base = g_addr.size();
        @(negedge iclk); set_dm(1'b1, LP_SIZE_B, 32'h0000_0203, 32'h0000_00AB);
        run_dm(1'b1, t, err);
        check_eq("sb_be", {28'd0, g_be[base]}, 32'h8);
        check_eq("sb_wdata", g_wdata[base], 32'hABAB_ABAB);
        check_eq("sb_we", g_we[base], 1'b1);
        check_eq("sb_addr", g_addr[base], 32'h0000_0200);
        check_eq("sb_err", err, 1'b0);
        check_eq("sb_latency", t, 4);
        base = g_addr.size();
        @(negedge iclk); set_dm(1'b1, LP_SIZE_H, 32'h0000_0202, 32'h0000_1234);
        run_dm(1'b1, t, err);
        check_eq("sh_be", {28'd0, g_be[base]}, 32'hC);
        check_eq("sh_wdata", g_wdata[base], 32'h1234_1234);
        base = g_addr.size();
        @(negedge iclk); set_dm(1'b1, LP_SIZE_B, 32'h0000_0200, 32'h0000_005A);
        run_dm(1'b1, t, err);
        check_eq("sb0_be", {28'd0, g_be[base]}, 32'h1);
        check_eq("sb0_wdata", g_wdata[base], 32'h5A5A_5A5A);
        base = g_addr.size();
        @(negedge iclk); set_dm(1'b1, LP_SIZE_H, 32'h0000_0201, 32'h0000_1234);
        run_dm(1'b0, t, err);
        check_eq("sh_mis_err", err, 1'b1);
        check_eq("sh_mis_time", t, 1);
        check_eq("sh_mis_nomem", g_addr.size() - base, 0);
        @(negedge iclk); set_dm(1'b0, LP_SIZE_W, 32'h0000_0202, 32'h0);
        run_dm(1'b0, t, err);
        check_eq("lw_mis_err", err, 1'b1);
        check_eq("lw_mis_nomem", g_addr.size() - base, 0);

        // Delayed grant
        gnt_delay = 3;
        @(negedge iclk); iif_req = 1'b1; iif_addr = 32'h0000_0110;
        run_until_if(1'b0, t_dm, t_if);
        check_eq("gnt_delay_latency", t_if, 7);
        check_eq("gnt_delay_rdata", oif_rdata, 32'hC0DE_0110);
        gnt_delay = 0;

        // Spurious response while idle
        @(posedge iclk); #1; spur = 1'b1;
        @(posedge iclk); #1; spur = 1'b0;
        seen = 0;
        repeat (4) begin
            @(posedge iclk); #1;
            if (oif_valid || odm_valid) seen++;
        end
        check_eq("spurious_no_valid", seen, 0);
        check_eq("spurious_rdata_hold", oif_rdata, 32'hC0DE_0110);

        // Reset while waiting for the response
        rsp_delay = 3;
        @(negedge iclk); iif_req = 1'b1; iif_addr = 32'h0000_0114;
        @(posedge iclk); @(posedge iclk); #2;
        irst = 1'b1;
        #1;
        check_eq("arst_omem_req", omem_req, 1'b0);
        check_eq("arst_omem_be", {28'd0, omem_be}, 32'h0);
        check_eq("arst_omem_addr", omem_addr, 32'h0);
        check_eq("arst_if_rdata", oif_rdata, 32'h0);
        check_eq("arst_dm_rdata", odm_rdata, 32'h0);
        iif_req = 1'b0;
        @(negedge iclk); irst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge iclk); #1;
            if (oif_valid || odm_valid) seen++;
        end
        check_eq("late_rvalid_ignored", seen, 0);
        check_eq("late_rvalid_rdata", oif_rdata, 32'h0);
        rsp_delay = 0;
        @(negedge iclk); iif_req = 1'b1; iif_addr = 32'h0000_0118;
        run_until_if(1'b0, t_dm, t_if);
        check_eq("post_rst_latency", t_if, 4);
        check_eq("post_rst_rdata", oif_rdata, 32'hC0DE_0118);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
- Shares one external memory port between two requesters: the pipeline instruction-fetch port and the load/store data port.
- Sequences each access through a request/grant/response handshake and returns read data to the winning requester.
- Produces stall requests that the hazard logic turns into the pipeline stall_f/stall_d controls.
- Sits between the riscv_dp datapath and the single-ported memory/bus interface.

Parameters:
- MP_DATA_WIDTH, 32, data bus width.
- MP_ADDR_WIDTH, 32, byte address width.
- MP_STARVE_LIMIT, 4, consecutive data grants allowed while a fetch is pending (range 1..2**MP_CNT_WIDTH-1).
- MP_CNT_WIDTH, 3, width of the starvation counter.

Ports:
- iclk  in  1  clock, rising edge.
- irst  in  1  reset, asynchronous, active-high.
- iif_req  in  1  fetch request; held until oif_valid.
- iif_addr  in  MP_ADDR_WIDTH  fetch address (word aligned).
- oif_rdata  out  MP_DATA_WIDTH  fetched instruction.
- oif_valid  out  1  one-cycle fetch completion pulse.
- idm_req  in  1  data request; held until odm_valid.
- idm_we  in  1  1 = store, 0 = load.
- idm_size  in  2  funct3[1:0]: 00 byte, 01 half, 10 word.
- idm_addr  in  MP_ADDR_WIDTH  data byte address.
- idm_wdata  in  MP_DATA_WIDTH  store data, right-aligned.
- odm_rdata  out  MP_DATA_WIDTH  raw load word (the load decoder extracts bytes/halves).
- odm_valid  out  1  one-cycle data completion pulse.
- odm_err  out  1  qualifies odm_valid: misaligned access, no memory cycle issued.
- omem_req  out  1  memory request.
- omem_we  out  1  memory write enable.
- omem_be  out  4  byte enables.
- omem_addr  out  MP_ADDR_WIDTH  word address (bits [1:0] = 0).
- omem_wdata  out  MP_DATA_WIDTH  lane-replicated store data.
- imem_gnt  in  1  memory accepted request this cycle.
- imem_rvalid  in  1  response valid (loads, fetches and store acks).
- imem_rdata  in  MP_DATA_WIDTH  memory read data.
- ostall_if  out  1  iif_req & ~oif_valid.
- ostall_dm  out  1  idm_req & ~odm_valid.

Behaviour:
- Reset: state IDLE, owner cleared, starvation counter 0. Every registered output is 0 (omem_*, oif_*, odm_*). Outstanding transaction is abandoned.
- FSM states: IDLE, REQ, RSP, DONE. Owner register: IF or DM.
- IDLE:
  - Pending requests are arbitrated; the winner's command is registered onto omem_*. Go to REQ.
  - Default priority: DM over IF.
  - IF wins if the counter equals MP_STARVE_LIMIT and iif_req is high.
  - Misaligned DM (half with addr[0]=1, word with addr[1:0]≠0): no memory cycle; odm_valid=1 and odm_err=1 pulse next cycle; stay in IDLE.
- REQ: omem_req held at 1 with stable command until imem_gnt is sampled high, then go to RSP and drop omem_req.
- RSP:
  - On imem_rvalid, capture imem_rdata into the owner's rdata register and go to DONE.
  - imem_rvalid sampled in IDLE or REQ is ignored.
- DONE: owner's valid pulses for exactly one cycle; return to IDLE. Arbitration resumes in the same cycle, so back-to-back transactions are possible.
- Latency: with gnt in the first REQ cycle and rvalid in the first RSP cycle, valid is asserted 4 cycles after req is first sampled.
- Starvation counter:
  - Increments on each DM grant while iif_req=1, saturating at the limit.
  - Clears on an IF grant or when iif_req=0.
- Byte enables:
  - byte: 4'b0001 << addr[1:0].
  - half: 4'b0011 << addr[1:0].
  - word: 4'b1111.
  - Fetch reads use 4'b1111.
- Store data: byte replicated to 4 lanes; half replicated to 2 lanes; word as-is.
- Requester deasserting req mid-transaction: the transaction still completes and valid still pulses; the requester ignores it. Do not abort.
- Both requests arriving simultaneously: DM is served first; the IF stall holds until IF is served.
- rdata outputs hold their last captured value between pulses.

Decomposition:
- Package riscv_mem_pkg holds:
  - FSM state encodings (LP_IDLE, LP_REQ, LP_RSP, LP_DONE).
  - Owner codes.
  - Size codes (LP_SIZE_B/H/W), shared with the load decoder.
- One sub-module: riscv_mem_lane. It is combinational: size + addr[1:0] + wdata → be, replicated wdata, misalign flag.

Test Plan:
- Fetch only: iif_req=1, addr 0x100, gnt immediate, rvalid next cycle with 0x00500093 → oif_valid pulses once, 4 cycles after req; oif_rdata=0x00500093; omem_be=4'hF; omem_we=0.
- Simultaneous req: iif_req=1 and idm_req=1 (load, addr 0x204) → DM served first; ostall_if held until the following IF completes; odm_valid precedes oif_valid.
- Starvation: idm_req held high continuously with iif_req=1, limit=4 → after 4 DM grants the next grant is IF; counter then clears.
- Stores: sb addr 0x203, wdata 0xAB → omem_be=4'b1000, omem_wdata=0xABABABAB. sh addr 0x202 → be=4'b1100. sh addr 0x201 → odm_err=1, no omem_req.
- Handshake: gnt delayed 3 cycles → omem_req and command stable throughout. Spurious rvalid in IDLE → no valid pulse.
- Reset: irst asserted while in RSP → all outputs 0 immediately (async); a late rvalid after reset is ignored; a fresh fetch completes normally.
